pc_redirect_ctrl: RTL and testbench

Sequencer for the core's program-counter register. It arbitrates control-flow redirect requests (trap entry, `mret`, taken branch/jump) and holds a redirect while the fetch bus is busy. It drives the PC register's `jump`/`jump_addr`/`stall_n` inputs, produces a pipeline flush window after every redirect, and implements WFI sleep. It sits between the execute/CSR/trap logic and the PC register in the RISC-V core.

---
 rtl/pc_redirect_ctrl.sv | 141 ++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// Program-counter redirect sequencer: arbitrates trap/mret/branch redirects, holds them while
// the fetch bus is busy, generates the post-redirect flush window and implements WFI sleep.
`timescale 1ns / 1ps
module pc_redirect_ctrl #(
    parameter int unsigned RVC_SUPPORT  = 0,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        trap_req,
    input  logic [31:0] trap_vector,
    input  logic        mret_req,
    input  logic [31:0] mepc,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        wfi_req,
    input  logic        irq_pending,
    input  logic        fetch_busy,
    output logic        pc_jump,
    output logic [31:0] pc_jump_addr,
    output logic        pc_stall_n,
    output logic        flush,
    output logic        sleeping
);

    typedef enum logic [1:0] {StRun, StPend, StFlush, StSleep} state_e;

    state_e      state_q;
    logic [2:0]  cnt_q;
    logic [31:0] pend_addr_q;
    logic [1:0]  pend_prio_q;

    logic        win_valid;
    logic [1:0]  win_prio;
    logic [31:0] win_raw;
    logic [31:0] win_addr;
    logic        sel_valid;
    logic        take_new;
    logic [31:0] eff_addr;
    logic [1:0]  eff_prio;

    // Fixed priority: lower number wins.
    always_comb begin
        win_valid = 1'b1;
        win_prio  = 2'd0;
        win_raw   = trap_vector;
        if (trap_req) begin
            win_prio = 2'd0;
            win_raw  = trap_vector;
        end else if (mret_req) begin
            win_prio = 2'd1;
            win_raw  = mepc;
        end else if (br_taken) begin
            win_prio = 2'd2;
            win_raw  = br_target;
        end else begin
            win_valid = 1'b0;
            win_raw   = 32'd0;
        end

        if (RVC_SUPPORT != 0) begin
            win_addr = {win_raw[31:1], 1'b0};
        end else begin
            win_addr = {win_raw[31:2], 2'b00};
        end

        // While asleep only a trap may wake the core through the redirect path.
        sel_valid = (state_q == StSleep) ? trap_req : win_valid;

        take_new = win_valid && (win_prio <= pend_prio_q);
        eff_addr = take_new ? win_addr : pend_addr_q;
        eff_prio = take_new ? win_prio : pend_prio_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            cnt_q        <= 3'd0;
            pend_addr_q  <= 32'd0;
            pend_prio_q  <= 2'd0;
            pc_jump      <= 1'b0;
            pc_jump_addr <= 32'd0;
            flush        <= 1'b0;
            sleeping     <= 1'b0;
        end else begin
            pc_jump <= 1'b0;
            case (state_q)
                StPend: begin
                    if (!fetch_busy) begin
                        pc_jump      <= 1'b1;
                        pc_jump_addr <= eff_addr;
                        cnt_q        <= 3'(FLUSH_CYCLES);
                        flush        <= 1'b1;
                        state_q      <= StFlush;
                    end else begin
                        pend_addr_q <= eff_addr;
                        pend_prio_q <= eff_prio;
                    end
                end
                default: begin
                    if (sel_valid) begin
                        sleeping <= 1'b0;
                        if (!fetch_busy) begin
                            pc_jump      <= 1'b1;
                            pc_jump_addr <= win_addr;
                            cnt_q        <= 3'(FLUSH_CYCLES);
                            flush        <= 1'b1;
                            state_q      <= StFlush;
                        end else begin
                            pend_addr_q <= win_addr;
                            pend_prio_q <= win_prio;
                            // Keep killing IF/ID if an earlier redirect is still flushing.
                            flush       <= (state_q == StFlush);
                            state_q     <= StPend;
                        end
                    end else if (state_q == StFlush) begin
                        if (cnt_q <= 3'd1) begin
                            cnt_q   <= 3'd0;
                            flush   <= 1'b0;
                            state_q <= StRun;
                        end else begin
                            cnt_q <= cnt_q - 3'd1;
                        end
                    end else if (state_q == StSleep) begin
                        if (irq_pending) begin
                            sleeping <= 1'b0;
                            state_q  <= StRun;
                        end
                    end else if (wfi_req && !irq_pending) begin
                        sleeping <= 1'b1;
                        state_q  <= StSleep;
                    end
                end
            endcase
        end
    end

    assign pc_stall_n = rst_n & ~fetch_busy & ((state_q == StRun) | (state_q == StFlush))
                        & ~pc_jump;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed self-checking bench for pc_redirect_ctrl with default parameters.
`timescale 1ns / 1ps
module tb_pc_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        trap_req, mret_req, br_taken, wfi_req, irq_pending, fetch_busy;
    logic [31:0] trap_vector, mepc, br_target;
    logic        pc_jump, pc_stall_n, flush, sleeping;
    logic [31:0] pc_jump_addr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_redirect_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trap_req     (trap_req),
        .trap_vector  (trap_vector),
        .mret_req     (mret_req),
        .mepc         (mepc),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .wfi_req      (wfi_req),
        .irq_pending  (irq_pending),
        .fetch_busy   (fetch_busy),
        .pc_jump      (pc_jump),
        .pc_jump_addr (pc_jump_addr),
        .pc_stall_n   (pc_stall_n),
        .flush        (flush),
        .sleeping     (sleeping)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge; inputs set afterwards apply next edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        trap_req = 1'b0;
        mret_req = 1'b0;
        br_taken = 1'b0;
        wfi_req  = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        clear_reqs();
        irq_pending = 1'b0;
        fetch_busy  = 1'b0;
        trap_vector = 32'd0;
        mepc        = 32'd0;
        br_target   = 32'd0;
        step();
        step();
        check("rst_jump", 32'(pc_jump), 32'd0);
        check("rst_addr", pc_jump_addr, 32'd0);
        check("rst_flush", 32'(flush), 32'd0);
        check("rst_sleep", 32'(sleeping), 32'd0);
        check("rst_stall", 32'(pc_stall_n), 32'd0);
        rst_n = 1'b1;
        #1;
        check("run_stall", 32'(pc_stall_n), 32'd1);
        step();

        // Priority + alignment: trap beats branch, 0x103 -> 0x100.
        trap_req    = 1'b1;
        br_taken    = 1'b1;
        trap_vector = 32'h0000_0103;
        br_target   = 32'h0000_0500;
        step();
        clear_reqs();
        #1;
        check("prio_jump", 32'(pc_jump), 32'd1);
        check("prio_addr", pc_jump_addr, 32'h0000_0100);
        check("prio_flush1", 32'(flush), 32'd1);
        check("prio_stall_jump", 32'(pc_stall_n), 32'd0);
        step();
        check("prio_jump_once", 32'(pc_jump), 32'd0);
        check("prio_flush2", 32'(flush), 32'd1);
        check("prio_stall_flush", 32'(pc_stall_n), 32'd1);
        step();
        check("prio_flush_end", 32'(flush), 32'd0);
        check("prio_no_jump", 32'(pc_jump), 32'd0);

        // Pending while busy for three cycles.
        br_taken   = 1'b1;
        br_target  = 32'h0000_0200;
        fetch_busy = 1'b1;
        #1;
        check("pend_stall_busy", 32'(pc_stall_n), 32'd0);
        step();
        clear_reqs();
        check("pend_nojump1", 32'(pc_jump), 32'd0);
        check("pend_stall1", 32'(pc_stall_n), 32'd0);
        step();
        check("pend_nojump2", 32'(pc_jump), 32'd0);
        step();
        fetch_busy = 1'b0;
        #1;
        check("pend_nojump3", 32'(pc_jump), 32'd0);
        check("pend_stall_idle", 32'(pc_stall_n), 32'd0);
        step();
        check("pend_jump", 32'(pc_jump), 32'd1);
        check("pend_addr", pc_jump_addr, 32'h0000_0200);
        check("pend_flush", 32'(flush), 32'd1);
        step();
        check("pend_jump_once", 32'(pc_jump), 32'd0);
        step();
        check("pend_flush_end", 32'(flush), 32'd0);

        // Pending override: mret replaces branch; later branch is dropped.
        br_taken   = 1'b1;
        br_target  = 32'h0000_0200;
        fetch_busy = 1'b1;
        step();
        clear_reqs();
        mret_req = 1'b1;
        mepc     = 32'h0000_0300;
        step();
        clear_reqs();
        br_taken  = 1'b1;
        br_target = 32'h0000_0400;
        check("ovr_nojump", 32'(pc_jump), 32'd0);
        step();
        clear_reqs();
        fetch_busy = 1'b0;
        step();
        check("ovr_jump", 32'(pc_jump), 32'd1);
        check("ovr_addr", pc_jump_addr, 32'h0000_0300);
        step();
        check("ovr_jump_once", 32'(pc_jump), 32'd0);
        step();
        check("ovr_flush_end", 32'(flush), 32'd0);
        check("ovr_addr_kept", pc_jump_addr, 32'h0000_0300);

        // Redirect during FLUSH issues back-to-back and reloads the counter.
        br_taken  = 1'b1;
        br_target = 32'h0000_0010;
        step();
        br_target = 32'h0000_0822;
        check("bb_jump1", 32'(pc_jump), 32'd1);
        step();
        clear_reqs();
        check("bb_jump2", 32'(pc_jump), 32'd1);
        check("bb_addr2", pc_jump_addr, 32'h0000_0820);
        step();
        check("bb_jump_once", 32'(pc_jump), 32'd0);
        check("bb_flush_reload", 32'(flush), 32'd1);
        step();
        check("bb_flush_end", 32'(flush), 32'd0);

        // WFI with no interrupt: sleep for 10 cycles, branches ignored.
        wfi_req = 1'b1;
        step();
        clear_reqs();
        for (int i = 0; i < 10; i++) begin
            br_taken  = (i == 4);
            br_target = 32'h0000_0600;
            #1;
            check("wfi_sleeping", 32'(sleeping), 32'd1);
            check("wfi_stall", 32'(pc_stall_n), 32'd0);
            check("wfi_nojump", 32'(pc_jump), 32'd0);
            step();
        end
        clear_reqs();
        irq_pending = 1'b1;
        step();
        irq_pending = 1'b0;
        #1;
        check("wake_sleeping", 32'(sleeping), 32'd0);
        check("wake_stall", 32'(pc_stall_n), 32'd1);
        check("wake_nojump", 32'(pc_jump), 32'd0);

        // WFI with interrupt already pending acts as a no-op.
        wfi_req     = 1'b1;
        irq_pending = 1'b1;
        step();
        clear_reqs();
        check("wfi_irq_sleep", 32'(sleeping), 32'd0);
        check("wfi_irq_stall", 32'(pc_stall_n), 32'd1);
        step();
        irq_pending = 1'b0;
        check("wfi_irq_sleep2", 32'(sleeping), 32'd0);

        // Trap wakes the core from sleep and redirects.
        wfi_req = 1'b1;
        step();
        clear_reqs();
        check("trap_sleep_in", 32'(sleeping), 32'd1);
        trap_req    = 1'b1;
        trap_vector = 32'h0000_0206;
        step();
        clear_reqs();
        check("trap_wake_jump", 32'(pc_jump), 32'd1);
        check("trap_wake_addr", pc_jump_addr, 32'h0000_0204);
        check("trap_wake_sleep", 32'(sleeping), 32'd0);
        step();
        step();
        check("trap_wake_flush_end", 32'(flush), 32'd0);

        // Reset while a redirect is pending.
        br_taken   = 1'b1;
        br_target  = 32'h0000_0700;
        fetch_busy = 1'b1;
        step();
        clear_reqs();
        rst_n = 1'b0;
        #1;
        check("mrst_jump", 32'(pc_jump), 32'd0);
        check("mrst_addr", pc_jump_addr, 32'd0);
        check("mrst_flush", 32'(flush), 32'd0);
        check("mrst_sleep", 32'(sleeping), 32'd0);
        check("mrst_stall", 32'(pc_stall_n), 32'd0);
        step();
        fetch_busy = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mrst_no_jump", 32'(pc_jump), 32'd0);
            check("mrst_no_flush", 32'(flush), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
